// File: rtl/adder_pkg.sv
// Shared widths and types for the bit-serial multi-operand adder.
// Holds no logic, so it adds no latency and has no backpressure.
package adder_pkg;

   localparam int M = 16;
   localparam int N = 4;

   function automatic int sum_width(input int lanes, input int width);
      return $clog2(lanes * (2 ** width - 1) + 1);
   endfunction

   function automatic int count_width(input int lanes);
      return $clog2(lanes + 1);
   endfunction

   localparam int RES_W = sum_width(M, N);
   localparam int PC_W  = count_width(M);
   localparam int CNT_W = $clog2(N);
   localparam int LVLS  = $clog2(M);

   typedef logic [M-1:0]     plane_t;
   typedef logic [RES_W-1:0] res_t;
   typedef logic [PC_W-1:0]  pc_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/popcount_cla.sv
// Combinational M-input popcount built as a tree of carry-lookahead adders.
// Zero latency; no backpressure, the output follows the input plane.
module popcount_cla
   import adder_pkg::*;
(
   input  logic [M-1:0]    plane,
   output logic [PC_W-1:0] count
);

   // Level l holds M>>l partial counts, each l+1 bits wide.
   for (genvar l = 0; l <= LVLS; l++) begin : lvl
      logic [l:0] s [M >> l];

      if (l == 0) begin : leaf
         for (genvar i = 0; i < M; i++) begin : lane
            assign s[i] = plane[i];
         end
      end else begin : add
         for (genvar i = 0; i < (M >> l); i++) begin : node
            logic [l-1:0] a, b, g, p;
            logic [l:0]   c;

            assign a = lvl[l-1].s[2*i];
            assign b = lvl[l-1].s[2*i+1];
            assign g = a & b;
            assign p = a ^ b;

            // Each carry is the flattened sum-of-products of generate/propagate terms.
            always_comb begin
               logic t;
               t = 1'b0;
               c = '0;
               for (int k = 0; k < l; k++) begin
                  for (int j = 0; j <= k; j++) begin
                     t = g[j];
                     for (int m = j + 1; m <= k; m++) begin
                        t = t & p[m];
                     end
                     c[k+1] = c[k+1] | t;
                  end
               end
            end

            assign s[i] = {c[l], p ^ c[l-1:0]};
         end
      end
   end

   assign count = lvl[LVLS].s[0];

endmodule

// File: rtl/parallel_adder_16x4.sv
// Bit-serial sum of M N-bit operands fed as bit-planes, LSB first; result updates on the edge sampling the last plane.
// No backpressure: every post-reset edge consumes one plane.
module parallel_adder_16x4
   import adder_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [M-1:0]     data_bits,
   output logic [RES_W-1:0] result
);

   cnt_t plane;
   pc_t  pc;
   res_t term;
   res_t acc;
   res_t sum;

   popcount_cla u_popcount (
      .plane (data_bits),
      .count (pc)
   );

   assign term = res_t'(pc) << plane;
   assign sum  = acc + term;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         plane  <= '0;
         acc    <= '0;
         result <= '0;
      end else if (plane == cnt_t'(N - 1)) begin
         result <= sum;
         acc    <= '0;
         plane  <= '0;
      end else begin
         acc   <= sum;
         plane <= plane + cnt_t'(1);
      end
   end

endmodule

// File: tb/tb_parallel_adder_16x4.sv
// Directed-vector bench for parallel_adder_16x4 with a queue-based scoreboard.
// Stimulus pushes the expected result for each edge; a monitor pops and compares.
module tb_parallel_adder_16x4;
   import adder_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic [M-1:0]     data_bits;
   logic [RES_W-1:0] result;

   int total = 0;
   int bad   = 0;
   int q[$];
   int exp_res = 0;

   parallel_adder_16x4 dut (
      .clk       (clk),
      .rst       (rst),
      .data_bits (data_bits),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // operand k lives in ops[4k+3:4k] and maps to lane M-1-k
   function automatic plane_t plane_of(input logic [63:0] ops, input int p);
      plane_t pl;
      pl = '0;
      for (int k = 0; k < M; k++) pl[M-1-k] = ops[4*k+p];
      return pl;
   endfunction

   task automatic drive(input plane_t pl, input logic last, input int sum);
      @(negedge clk);
      rst = 1'b0;
      data_bits = pl;
      if (last) exp_res = sum;
      q.push_back(exp_res);
   endtask

   task automatic send_planes(input plane_t p0, input plane_t p1, input plane_t p2,
                              input plane_t p3, input int sum);
      drive(p0, 1'b0, sum);
      drive(p1, 1'b0, sum);
      drive(p2, 1'b0, sum);
      drive(p3, 1'b1, sum);
   endtask

   task automatic send_frame(input logic [63:0] ops, input int sum);
      send_planes(plane_of(ops, 0), plane_of(ops, 1), plane_of(ops, 2), plane_of(ops, 3), sum);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      data_bits = '0;
      exp_res = 0;
      #1 check("rst_async", int'(result), 0);
      @(posedge clk);
      #1 check("rst_hold", int'(result), 0);
   endtask

   // monitor: one expected value per consumed plane
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst && q.size() > 0) begin
            int e;
            e = q.pop_front();
            check("result", int'(result), e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b0;
      data_bits = '0;
      #1 rst = 1'b1;
      #1 check("rst_init", int'(result), 0);

      do_reset();
      send_frame(64'h1764_3212_1764_3212, 52);

      do_reset();
      send_frame(64'hFFFF_FFFF_FFFF_FFFF, 240);

      do_reset();
      send_frame(64'h0000_0000_0000_0000, 0);

      do_reset();
      send_frame(64'h0000_0000_0000_000F, 15);

      do_reset();
      send_planes(16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 128);

      do_reset();
      send_planes(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1);

      do_reset();
      send_planes(16'h00FF, 16'h0F0F, 16'h3333, 16'h5555, 120);

      // back-to-back frames, then a reset part-way through a third
      do_reset();
      send_frame(64'h1764_3212_1764_3212, 52);
      send_frame(64'hFFFF_FFFF_FFFF_FFFF, 240);
      drive(16'hFFFF, 1'b0, 0);
      drive(16'hFFFF, 1'b0, 0);
      do_reset();
      send_frame(64'h1111_1111_1111_1111, 16);

      @(negedge clk);
      check("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
